adc3_seq: RTL and testbench

//  Conversion sequencer directly upstream of the SOL/BB ADC interface: issues adc_convert/convert_slow on a

---
 rtl/adc3_seq_pkg.sv | 18 +
 rtl/adc_tick_gen.sv | 29 ++
 rtl/adc3_seq.sv | 127 ++++++++++++
 tb/tb_adc3_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc3_seq_pkg.sv
// Shared definitions for the ADC conversion sequencer: sample width,
// default scheduling constants and FSM state encoding.
package adc3_seq_pkg;

  localparam int ADC_W        = 12;
  localparam int PERIOD_DEF   = 1024;
  localparam int BB_RATIO_DEF = 8;
  localparam int TIMEOUT_DEF  = 600;
  localparam int GUARD_DEF    = 40;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_START    = 2'b01,
    S_WAIT_VAL = 2'b10,
    S_GUARD    = 2'b11
  } seq_state_e;

endpackage

// File: rtl/adc_tick_gen.sv
// Period timer: counts 0..PERIOD-1 while enabled and flags the last count
// as the conversion tick. Disabling the timer clears it.
module adc_tick_gen
  import adc3_seq_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic tx_clk,
  input  logic tx_rst_n,
  input  logic en,
  output logic tick
);

  logic [15:0] cnt_q;

  assign tick = en && (cnt_q == 16'(PERIOD - 1));

  // Free-running period counter, held at zero while disabled.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/adc3_seq.sv
// SOL/BB conversion sequencer: schedules fast (SOL) and slow (BB) ADC
// conversions, waits for the sample with a timeout, enforces a guard gap
// and routes each sample to its own hold register with a valid strobe.
module adc3_seq
  import adc3_seq_pkg::*;
#(
  parameter int PERIOD   = PERIOD_DEF,
  parameter int BB_RATIO = BB_RATIO_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int GUARD    = GUARD_DEF
) (
  input  logic             tx_clk,
  input  logic             tx_rst_n,
  input  logic             seq_en,
  input  logic             bb_force,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_data_val,
  output logic             adc_convert,
  output logic             convert_slow,
  output logic [ADC_W-1:0] sol_data,
  output logic             sol_val,
  output logic [ADC_W-1:0] bb_data,
  output logic             bb_val,
  output logic             busy,
  output logic             timeout_err,
  output logic             overrun_err
);

  localparam int RW = (BB_RATIO > 1) ? $clog2(BB_RATIO) : 1;

  seq_state_e    state_q, state_d;
  logic          tick;
  logic          accept;
  logic          slow_sel;
  logic          capture;
  logic          expire;
  logic [RW-1:0] ratio_q;
  logic [15:0]   cnt_q;
  logic          force_q;
  logic          forced_q;
  logic          src_q;

  adc_tick_gen #(.PERIOD(PERIOD)) u_tick_gen (
    .tx_clk   (tx_clk),
    .tx_rst_n (tx_rst_n),
    .en       (seq_en),
    .tick     (tick)
  );

  assign accept   = (state_q == S_IDLE) && tick;
  assign slow_sel = force_q || (ratio_q == RW'(BB_RATIO - 1));
  assign capture  = (state_q == S_WAIT_VAL) && adc_data_val;
  // The wait count starts in START, so expiry lands TIMEOUT cycles after
  // the start strobe; a coincident valid takes precedence.
  assign expire   = (state_q == S_WAIT_VAL) && !adc_data_val &&
                    (cnt_q == 16'(TIMEOUT - 1));

  // Next-state logic for the conversion FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (tick) state_d = S_START;
      S_START:    state_d = S_WAIT_VAL;
      S_WAIT_VAL: if (adc_data_val || (cnt_q == 16'(TIMEOUT - 1))) state_d = S_GUARD;
      S_GUARD:    if (cnt_q == 16'(GUARD - 1)) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Wait/guard counter, ratio counter, bb_force latch and source capture.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      cnt_q    <= '0;
      ratio_q  <= '0;
      force_q  <= 1'b0;
      forced_q <= 1'b0;
      src_q    <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) || ((state_q == S_WAIT_VAL) && (state_d == S_GUARD)))
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 16'd1;
      // A new request wins over the clear so a pulse during START is kept.
      force_q <= bb_force || (force_q && !((state_q == S_START) && forced_q));
      if (accept) begin
        src_q    <= slow_sel;
        forced_q <= force_q;
      end
      if (state_q == S_START) begin
        if (forced_q || (ratio_q == RW'(BB_RATIO - 1))) ratio_q <= '0;
        else                                            ratio_q <= ratio_q + RW'(1);
      end
    end
  end

  // Registered outputs: start strobe, status pulses and sample routing.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      adc_convert  <= 1'b0;
      convert_slow <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
      sol_val      <= 1'b0;
      bb_val       <= 1'b0;
      sol_data     <= '0;
      bb_data      <= '0;
    end else begin
      adc_convert  <= accept;
      convert_slow <= accept && slow_sel;
      busy         <= (state_d != S_IDLE);
      timeout_err  <= expire;
      overrun_err  <= tick && (state_q != S_IDLE);
      sol_val      <= capture && !src_q;
      bb_val       <= capture && src_q;
      if (capture && !src_q) sol_data <= adc_data;
      if (capture && src_q)  bb_data  <= adc_data;
    end
  end

endmodule

// File: tb/tb_adc3_seq.sv
// Directed bench for adc3_seq: schedule pattern, forced BB, timeout,
// seq_en drop, reset mid-conversion (PERIOD=1024 instance) and overrun
// (PERIOD=100 instance).
module tb_adc3_seq;

  logic        tx_clk = 1'b0;
  logic        tx_rst_n = 1'b0;
  logic        seq_en_a = 1'b0;
  logic        seq_en_b = 1'b0;
  logic        bb_force = 1'b0;
  logic        adc_data_val = 1'b0;
  logic [11:0] adc_data = 12'h000;

  logic        a_convert, a_slow, a_sol_val, a_bb_val, a_busy, a_timeout, a_overrun;
  logic [11:0] a_sol_data, a_bb_data;
  logic        b_convert, b_slow, b_sol_val, b_bb_val, b_busy, b_timeout, b_overrun;
  logic [11:0] b_sol_data, b_bb_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [11:0] exp_sol = 12'h000;
  logic [11:0] exp_bb = 12'h000;

  always #5 tx_clk = ~tx_clk;

  adc3_seq #(.PERIOD(1024), .BB_RATIO(4), .TIMEOUT(600), .GUARD(40)) dut_a (
    .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .seq_en(seq_en_a), .bb_force(bb_force),
    .adc_data(adc_data), .adc_data_val(adc_data_val),
    .adc_convert(a_convert), .convert_slow(a_slow),
    .sol_data(a_sol_data), .sol_val(a_sol_val), .bb_data(a_bb_data), .bb_val(a_bb_val),
    .busy(a_busy), .timeout_err(a_timeout), .overrun_err(a_overrun)
  );

  adc3_seq #(.PERIOD(100), .BB_RATIO(1), .TIMEOUT(600), .GUARD(40)) dut_b (
    .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .seq_en(seq_en_b), .bb_force(1'b0),
    .adc_data(adc_data), .adc_data_val(adc_data_val),
    .adc_convert(b_convert), .convert_slow(b_slow),
    .sol_data(b_sol_data), .sol_val(b_sol_val), .bb_data(b_bb_data), .bb_val(b_bb_val),
    .busy(b_busy), .timeout_err(b_timeout), .overrun_err(b_overrun)
  );

  task automatic step();
    @(posedge tx_clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_convert"}, a_convert, 1'b0);
    check({tag, "_slow"}, a_slow, 1'b0);
    check({tag, "_sol_data"}, a_sol_data, 12'h000);
    check({tag, "_bb_data"}, a_bb_data, 12'h000);
    check({tag, "_sol_val"}, a_sol_val, 1'b0);
    check({tag, "_bb_val"}, a_bb_val, 1'b0);
    check({tag, "_busy"}, a_busy, 1'b0);
    check({tag, "_timeout"}, a_timeout, 1'b0);
    check({tag, "_overrun"}, a_overrun, 1'b0);
  endtask

  task automatic wait_conv_a(input string tag, output int s);
    int n;
    n = 0;
    while (!a_convert && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_start_seen"}, a_convert, 1'b1);
    s = cyc;
  endtask

  task automatic deliver_a(input string tag, input logic exp_slow, input int lat,
                           input logic [11:0] data, output int s);
    wait_conv_a(tag, s);
    check({tag, "_slow"}, a_slow, exp_slow);
    repeat (lat) step();
    adc_data = data;
    adc_data_val = 1'b1;
    step();
    adc_data_val = 1'b0;
    if (exp_slow) exp_bb = data;
    else          exp_sol = data;
    check({tag, "_sol_val"}, a_sol_val, !exp_slow);
    check({tag, "_bb_val"}, a_bb_val, exp_slow);
    check({tag, "_sol_data"}, a_sol_data, exp_sol);
    check({tag, "_bb_data"}, a_bb_data, exp_bb);
  endtask

  initial begin
    int s;
    int n;
    int cnt_conv;
    int cnt_ovr;
    int cnt_bbv;
    logic sv;

    // Reset state
    repeat (3) step();
    check_clear("reset");
    tx_rst_n = 1'b1;
    step();
    check("post_reset_busy", a_busy, 1'b0);

    // Normal schedule: SOL x3 then BB, twice
    seq_en_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      deliver_a("sched", (i % 4) == 3, 20, 12'hA5A, s);
    end

    // One SOL leaves ratio_cnt at 1, then bb_force 10 cycles before the tick
    deliver_a("pre_force", 1'b0, 20, 12'h123, s);
    while (cyc < s + 1013) step();
    bb_force = 1'b1;
    step();
    bb_force = 1'b0;
    deliver_a("forced", 1'b1, 20, 12'h7E1, s);
    deliver_a("after_force0", 1'b0, 20, 12'h0F0, s);
    deliver_a("after_force1", 1'b0, 20, 12'h00F, s);
    deliver_a("after_force2", 1'b0, 20, 12'hFFF, s);
    deliver_a("after_force3", 1'b1, 20, 12'h800, s);

    // Timeout: no valid returned
    wait_conv_a("tmo", s);
    check("tmo_slow", a_slow, 1'b0);
    n = 0;
    sv = 1'b0;
    while (!a_timeout && n < 2000) begin
      step();
      n++;
      if (a_sol_val || a_bb_val) sv = 1'b1;
    end
    check("tmo_seen", a_timeout, 1'b1);
    check("tmo_latency", cyc - s, 600);
    check("tmo_no_val", sv, 1'b0);
    check("tmo_sol_data", a_sol_data, exp_sol);
    check("tmo_busy_guard", a_busy, 1'b1);
    step();
    check("tmo_pulse_width", a_timeout, 1'b0);
    // Stray valid during GUARD is ignored
    adc_data = 12'h555;
    adc_data_val = 1'b1;
    step();
    adc_data_val = 1'b0;
    check("guard_stray_val", a_sol_val, 1'b0);
    check("guard_stray_data", a_sol_data, exp_sol);
    deliver_a("after_tmo", 1'b0, 20, 12'h3C3, s);

    // seq_en dropped 2 cycles after START
    wait_conv_a("en_drop", s);
    step();
    step();
    seq_en_a = 1'b0;
    repeat (10) step();
    adc_data = 12'h2B4;
    adc_data_val = 1'b1;
    step();
    adc_data_val = 1'b0;
    exp_sol = 12'h2B4;
    check("en_drop_sol_val", a_sol_val, 1'b1);
    check("en_drop_sol_data", a_sol_data, exp_sol);
    check("en_drop_busy_guard", a_busy, 1'b1);
    cnt_conv = 0;
    for (int k = 0; k < 1200; k++) begin
      step();
      if (a_convert) cnt_conv++;
    end
    check("en_drop_no_start", cnt_conv, 0);
    check("en_drop_idle", a_busy, 1'b0);

    // Reset during WAIT_VAL, then a stray valid after release
    seq_en_a = 1'b1;
    wait_conv_a("rst_mid", s);
    check("rst_mid_slow", a_slow, 1'b1);
    repeat (5) step();
    check("rst_mid_busy_before", a_busy, 1'b1);
    tx_rst_n = 1'b0;
    #1;
    check_clear("rst_async");
    seq_en_a = 1'b0;
    step();
    tx_rst_n = 1'b1;
    step();
    adc_data = 12'hABC;
    adc_data_val = 1'b1;
    step();
    adc_data_val = 1'b0;
    check_clear("rst_stray");
    step();
    check("rst_stray_sol_val2", a_sol_val, 1'b0);
    check("rst_stray_bb_val2", a_bb_val, 1'b0);

    // Overrun: PERIOD=100, slow conversion returns after 530 cycles
    seq_en_b = 1'b1;
    n = 0;
    while (!b_convert && n < 300) begin
      step();
      n++;
    end
    check("ovr_start_seen", b_convert, 1'b1);
    check("ovr_slow", b_slow, 1'b1);
    s = cyc;
    cnt_conv = 0;
    cnt_ovr = 0;
    cnt_bbv = 0;
    for (int k = 1; k <= 599; k++) begin
      step();
      if (b_convert) cnt_conv++;
      if (b_overrun) cnt_ovr++;
      if (b_bb_val) cnt_bbv++;
      if (k == 530) begin
        adc_data = 12'h5A5;
        adc_data_val = 1'b1;
      end else begin
        adc_data_val = 1'b0;
      end
    end
    check("ovr_no_extra_start", cnt_conv, 0);
    check("ovr_count", cnt_ovr, 5);
    check("ovr_bb_val_count", cnt_bbv, 1);
    check("ovr_bb_data", b_bb_data, 12'h5A5);
    check("ovr_idle_before_tick", b_busy, 1'b0);
    step();
    check("ovr_next_start", b_convert, 1'b1);
    check("ovr_next_start_time", cyc - s, 600);
    seq_en_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
